alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester front end for one shared 8-bit ALU. A round-robin arbiter
// accepts one request at a time. The accepted operands are held on the ALU
// ports for HOLD_CYCLES cycles. On the last of those cycles the ALU result is
// registered and then presented on a valid/ready response port. Divide or
// modulo by zero is answered straight away with an error response, and the
// ALU is not used for it.
//
// Parameters
//   HOLD_CYCLES   1..15  cycles the operands stay on the ALU before capture
//
// Ports
//   i_clk         rising-edge clock
//   i_rst_n       asynchronous active-low reset
//   i_req_valid   [1:0]  per-requester request valid
//   o_req_ready   [1:0]  per-requester accept (one-hot or zero, IDLE only)
//   i_req_op      [13:0] op code per requester, requester k at [7k+6:7k]
//   i_req_a/b     [15:0] operands per requester, requester k at [8k+7:8k]
//   i_req_signed  [1:0]  signed-overflow select per requester
//   o_alu_A/B     [7:0]  operands to the shared ALU
//   o_alu_op      [6:0]  op code to the shared ALU
//   o_alu_signed         signed select to the shared ALU
//   i_alu_G       [7:0]  ALU result
//   i_alu_flags   [5:0]  {carry_out, equal, less_than, zero, one, overflow}
//   o_rsp_valid / i_rsp_ready   response handshake
//   o_rsp_id             requester that owns the response
//   o_rsp_G       [7:0]  registered result
//   o_rsp_flags   [5:0]  registered flags, same order as i_alu_flags
//   o_rsp_err            divide or modulo by zero
// -----------------------------------------------------------------------------

`ifndef MATH_ADD
`define MATH_ADD 7'h00
`endif
`ifndef MATH_SUB
`define MATH_SUB 7'h01
`endif
`ifndef MATH_MUL
`define MATH_MUL 7'h02
`endif
`ifndef MATH_DIV
`define MATH_DIV 7'h03
`endif
`ifndef MATH_MOD
`define MATH_MOD 7'h04
`endif
`ifndef MATH_AND
`define MATH_AND 7'h05
`endif
`ifndef MATH_OR
`define MATH_OR 7'h06
`endif
`ifndef MATH_XOR
`define MATH_XOR 7'h07
`endif

module alu_arbiter #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [13:0] i_req_op,
  input  logic [15:0] i_req_a,
  input  logic [15:0] i_req_b,
  input  logic [1:0]  i_req_signed,
  output logic [7:0]  o_alu_A,
  output logic [7:0]  o_alu_B,
  output logic [6:0]  o_alu_op,
  output logic        o_alu_signed,
  input  logic [7:0]  i_alu_G,
  input  logic [5:0]  i_alu_flags,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [7:0]  o_rsp_G,
  output logic [5:0]  o_rsp_flags,
  output logic        o_rsp_err
);

  localparam int DATA_W = 8;
  localparam int OP_W   = 7;
  localparam int FLAG_W = 6;

  // Reload value of the 4-bit hold counter: it counts HOLD_CYCLES-1 down to 0.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              rr_pri_q;     // requester favoured when both are valid
  logic [3:0]        hold_cnt_q;

  logic [1:0]        grant;
  logic              hs;
  logic              hs_id;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_signed;
  logic              div0;
  logic              exec_done;

  logic [DATA_W-1:0] alu_a_p0;
  logic [DATA_W-1:0] alu_b_p0;
  logic [OP_W-1:0]   alu_op_p0;
  logic              alu_signed_p0;

  logic              rsp_id_p1;
  logic [DATA_W-1:0] rsp_g_p1;
  logic [FLAG_W-1:0] rsp_flags_p1;
  logic              rsp_err_p1;
  logic              vld_p1;

  // Arbitration: a lone valid requester always wins. When both are valid the
  // requester that did not win last time wins. Ready is only offered in IDLE,
  // so a handshake can never overlap an operation in flight.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      case (i_req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_pri_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign o_req_ready = grant;
  assign hs          = |grant;
  assign hs_id       = grant[1];

  assign sel_op     = hs_id ? i_req_op[13:7] : i_req_op[6:0];
  assign sel_a      = hs_id ? i_req_a[15:8]  : i_req_a[7:0];
  assign sel_b      = hs_id ? i_req_b[15:8]  : i_req_b[7:0];
  assign sel_signed = hs_id ? i_req_signed[1] : i_req_signed[0];

  assign div0 = ((sel_op == `MATH_DIV) || (sel_op == `MATH_MOD)) &&
                (sel_b == '0);

  assign exec_done = (state_q == EXEC) && (hold_cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = div0 ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (hold_cnt_q == 4'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rr_pri_q   <= 1'b0;
      hold_cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        rr_pri_q   <= ~hs_id;
        hold_cnt_q <= HOLD_LOAD;
      end else if ((state_q == EXEC) && (hold_cnt_q != 4'd0)) begin
        hold_cnt_q <= hold_cnt_q - 4'd1;
      end
    end
  end

  // ---- stage p0: request capture, drives the shared ALU ----
  // A divide-by-zero request never reaches the ALU. The ALU ports therefore
  // keep the operands of the last real operation, and the ALU inputs do not
  // toggle for a request whose answer is already known.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_a_p0      <= '0;
      alu_b_p0      <= '0;
      alu_op_p0     <= '0;
      alu_signed_p0 <= 1'b0;
    end else if (hs && !div0) begin
      alu_a_p0      <= sel_a;
      alu_b_p0      <= sel_b;
      alu_op_p0     <= sel_op;
      alu_signed_p0 <= sel_signed;
    end
  end

  assign o_alu_A      = alu_a_p0;
  assign o_alu_B      = alu_b_p0;
  assign o_alu_op     = alu_op_p0;
  assign o_alu_signed = alu_signed_p0;

  // ---- stage p1: response register, held until the consumer takes it ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_id_p1    <= 1'b0;
      rsp_g_p1     <= '0;
      rsp_flags_p1 <= '0;
      rsp_err_p1   <= 1'b0;
    end else if (hs) begin
      rsp_id_p1 <= hs_id;
      if (div0) begin
        rsp_g_p1     <= '0;
        rsp_flags_p1 <= '0;
        rsp_err_p1   <= 1'b1;
      end
    end else if (exec_done) begin
      rsp_g_p1     <= i_alu_G;
      rsp_flags_p1 <= i_alu_flags;
      rsp_err_p1   <= 1'b0;
    end
  end

  assign vld_p1      = (state_q == RESP);
  assign o_rsp_valid = vld_p1;
  assign o_rsp_id    = rsp_id_p1;
  assign o_rsp_G     = rsp_g_p1;
  assign o_rsp_flags = rsp_flags_p1;
  assign o_rsp_err   = rsp_err_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Two instances of alu_arbiter share one set of request inputs. One instance
// uses HOLD_CYCLES=1 and the other HOLD_CYCLES=3. Each instance has its own
// behavioural ALU, its own reference model that predicts grants and queues the
// expected responses, and its own monitor that pops the queue and compares it
// with the response port.
// -----------------------------------------------------------------------------

`ifndef MATH_ADD
`define MATH_ADD 7'h00
`endif
`ifndef MATH_SUB
`define MATH_SUB 7'h01
`endif
`ifndef MATH_MUL
`define MATH_MUL 7'h02
`endif
`ifndef MATH_DIV
`define MATH_DIV 7'h03
`endif
`ifndef MATH_MOD
`define MATH_MOD 7'h04
`endif
`ifndef MATH_AND
`define MATH_AND 7'h05
`endif
`ifndef MATH_OR
`define MATH_OR 7'h06
`endif
`ifndef MATH_XOR
`define MATH_XOR 7'h07
`endif

module tb_alu_arbiter;

  localparam int NDUT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [13:0] req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_signed;
  logic        rsp_ready;

  logic [1:0]  req_ready  [NDUT];
  logic [7:0]  alu_A      [NDUT];
  logic [7:0]  alu_B      [NDUT];
  logic [6:0]  alu_op     [NDUT];
  logic        alu_signed [NDUT];
  logic [7:0]  alu_G      [NDUT];
  logic [5:0]  alu_flags  [NDUT];
  logic        rsp_valid  [NDUT];
  logic        rsp_id     [NDUT];
  logic [7:0]  rsp_G      [NDUT];
  logic [5:0]  rsp_flags  [NDUT];
  logic        rsp_err    [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic       id;
    logic [7:0] g;
    logic [5:0] f;
    logic       err;
    int         rise;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, req, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic. It returns {G, carry, equal,
  // less_than, zero, one, overflow}.
  function automatic logic [13:0] alu_ref(input logic [6:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic sgn);
    int ua, ub, sa, sb, r, sr;
    logic [7:0] g;
    logic c, ov, eq, lt;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    g = 8'h00; c = 1'b0; ov = 1'b0; r = 0; sr = 0;
    case (op)
      `MATH_ADD: begin r = ua + ub; g = r[7:0]; c = (r > 255); sr = sa + sb;
                       ov = sgn && (sr > 127 || sr < -128); end
      `MATH_SUB: begin r = ua - ub; g = r[7:0]; c = (ua < ub); sr = sa - sb;
                       ov = sgn && (sr > 127 || sr < -128); end
      `MATH_MUL: begin r = ua * ub; g = r[7:0]; c = (r > 255); end
      `MATH_DIV: begin r = (ub != 0) ? ua / ub : 0; g = r[7:0]; end
      `MATH_MOD: begin r = (ub != 0) ? ua % ub : 0; g = r[7:0]; end
      `MATH_AND: g = a & b;
      `MATH_OR:  g = a | b;
      `MATH_XOR: g = a ^ b;
      default:   g = 8'h00;
    endcase
    eq = (ua == ub);
    lt = sgn ? (sa < sb) : (ua < ub);
    return {g, c, eq, lt, (g == 8'h00), (g == 8'h01), ov};
  endfunction

  // Arbitration rule: a lone valid requester wins, and when both are valid
  // the favoured one wins.
  function automatic logic [1:0] arb(input logic [1:0] v, input logic fav);
    if (v == 2'b11) return fav ? 2'b10 : 2'b01;
    return v;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int HOLD = (g == 0) ? 1 : 3;

    alu_arbiter #(.HOLD_CYCLES(HOLD)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready[g]),
      .i_req_op     (req_op),
      .i_req_a      (req_a),
      .i_req_b      (req_b),
      .i_req_signed (req_signed),
      .o_alu_A      (alu_A[g]),
      .o_alu_B      (alu_B[g]),
      .o_alu_op     (alu_op[g]),
      .o_alu_signed (alu_signed[g]),
      .i_alu_G      (alu_G[g]),
      .i_alu_flags  (alu_flags[g]),
      .o_rsp_valid  (rsp_valid[g]),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_id     (rsp_id[g]),
      .o_rsp_G      (rsp_G[g]),
      .o_rsp_flags  (rsp_flags[g]),
      .o_rsp_err    (rsp_err[g])
    );

    assign {alu_G[g], alu_flags[g]} = alu_ref(alu_op[g], alu_A[g], alu_B[g], alu_signed[g]);

    exp_t q[$];
    logic       busy = 1'b0;
    logic       fav  = 1'b0;
    int         rise = 0;
    logic [7:0] la = 8'h00, lb = 8'h00;
    logic [6:0] lop = 7'h00;
    logic       ls = 1'b0;

    // Reference model: predicts ready and the ALU port values, and queues one
    // expected response for every accepted request.
    always @(negedge clk) begin
      logic [1:0]  er;
      logic        id, s;
      logic [6:0]  op;
      logic [7:0]  a, b;
      logic [13:0] r;
      exp_t        e;
      if (!rst_n) begin
        busy = 1'b0; fav = 1'b0; la = 8'h00; lb = 8'h00; lop = 7'h00; ls = 1'b0;
        q.delete();
      end else begin
        er = busy ? 2'b00 : arb(req_valid, fav);
        chk("req_ready", g, 32'(req_ready[g]), 32'(er));
        chk("alu_A", g, 32'(alu_A[g]), 32'(la));
        chk("alu_B", g, 32'(alu_B[g]), 32'(lb));
        chk("alu_op", g, 32'(alu_op[g]), 32'(lop));
        chk("alu_signed", g, 32'(alu_signed[g]), 32'(ls));
        if (busy) begin
          if (cyc >= rise && rsp_ready) busy = 1'b0;
        end else if (er != 2'b00) begin
          id = er[1];
          op = req_op[7*id +: 7];
          a  = req_a[8*id +: 8];
          b  = req_b[8*id +: 8];
          s  = req_signed[id];
          fav  = ~id;
          busy = 1'b1;
          if ((op == `MATH_DIV || op == `MATH_MOD) && b == 8'h00) begin
            rise = cyc + 1;
            e = '{id, 8'h00, 6'h00, 1'b1, rise};
          end else begin
            rise = cyc + HOLD + 1;
            r = alu_ref(op, a, b, s);
            e = '{id, r[13:6], r[5:0], 1'b0, rise};
            la = a; lb = b; lop = op; ls = s;
          end
          q.push_back(e);
        end
      end
    end

    // Monitor: compares the response port with the head of the queue.
    always @(negedge clk) begin
      logic ev;
      if (rst_n) begin
        ev = (q.size() > 0) && (cyc >= q[0].rise);
        chk("rsp_valid", g, 32'(rsp_valid[g]), 32'(ev));
        if (ev) begin
          chk("rsp_id", g, 32'(rsp_id[g]), 32'(q[0].id));
          chk("rsp_G", g, 32'(rsp_G[g]), 32'(q[0].g));
          chk("rsp_flags", g, 32'(rsp_flags[g]), 32'(q[0].f));
          chk("rsp_err", g, 32'(rsp_err[g]), 32'(q[0].err));
          if (rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic set_req(input int k, input logic [6:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic s);
    req_op[7*k +: 7] = op;
    req_a[8*k +: 8]  = a;
    req_b[8*k +: 8]  = b;
    req_signed[k]    = s;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic one_shot(input logic [1:0] v, input int wait_n);
    req_valid = v;
    cycles(1);
    req_valid = 2'b00;
    cycles(wait_n);
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk({tag, "_rsp_valid"}, d, 32'(rsp_valid[d]), 32'd0);
      chk({tag, "_rsp_id"}, d, 32'(rsp_id[d]), 32'd0);
      chk({tag, "_rsp_G"}, d, 32'(rsp_G[d]), 32'd0);
      chk({tag, "_rsp_flags"}, d, 32'(rsp_flags[d]), 32'd0);
      chk({tag, "_rsp_err"}, d, 32'(rsp_err[d]), 32'd0);
      chk({tag, "_alu_A"}, d, 32'(alu_A[d]), 32'd0);
      chk({tag, "_alu_B"}, d, 32'(alu_B[d]), 32'd0);
      chk({tag, "_alu_op"}, d, 32'(alu_op[d]), 32'd0);
      chk({tag, "_alu_signed"}, d, 32'(alu_signed[d]), 32'd0);
      chk({tag, "_req_ready"}, d, 32'(req_ready[d]), 32'd0);
    end
  endtask

  function automatic logic [6:0] rnd_op();
    case ($urandom_range(0, 9))
      0: return `MATH_ADD;
      1: return `MATH_SUB;
      2: return `MATH_MUL;
      3: return `MATH_DIV;
      4: return `MATH_MOD;
      5: return `MATH_AND;
      6: return `MATH_OR;
      7: return `MATH_XOR;
      8: return 7'h7F;
      default: return 7'($urandom_range(8, 126));
    endcase
  endfunction

  initial begin
    rst_n = 1'b1;
    req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; req_signed = '0;
    rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset");
    // The pointer favours requester 0 while reset is held.
    req_valid = 2'b11;
    #1;
    for (int d = 0; d < NDUT; d++) chk("reset_rr", d, 32'(req_ready[d]), 32'd1);
    req_valid = 2'b00;
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycles(1);

    // Unsigned add with carry out.
    set_req(0, `MATH_ADD, 8'd200, 8'd100, 1'b0);
    one_shot(2'b01, 6);

    // Both requesters valid on every cycle, so the grants alternate.
    set_req(0, `MATH_SUB, 8'd5, 8'd3, 1'b0);
    set_req(1, `MATH_SUB, 8'd3, 8'd5, 1'b0);
    req_valid = 2'b11;
    cycles(24);
    req_valid = 2'b00;
    cycles(6);

    // Divide by zero from requester 1.
    set_req(1, `MATH_DIV, 8'd9, 8'd0, 1'b0);
    one_shot(2'b10, 4);

    // Signed and unsigned overflow.
    set_req(0, `MATH_ADD, 8'd100, 8'd100, 1'b1);
    one_shot(2'b01, 6);
    set_req(0, `MATH_ADD, 8'd100, 8'd100, 1'b0);
    one_shot(2'b01, 6);

    // Unknown op code, modulo by zero and an ordinary divide.
    set_req(1, 7'h7F, 8'd3, 8'd4, 1'b0);
    one_shot(2'b10, 6);
    set_req(0, `MATH_MOD, 8'd17, 8'd0, 1'b0);
    one_shot(2'b01, 4);
    set_req(1, `MATH_DIV, 8'd200, 8'd7, 1'b0);
    one_shot(2'b10, 6);

    // Response back-pressure while the request inputs keep changing.
    rsp_ready = 1'b0;
    set_req(0, `MATH_ADD, 8'd7, 8'd9, 1'b0);
    req_valid = 2'b01;
    cycles(1);
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      set_req(0, rnd_op(), 8'($urandom), 8'($urandom), 1'($urandom));
      set_req(1, rnd_op(), 8'($urandom), 8'($urandom), 1'($urandom));
      cycles(1);
    end
    rsp_ready = 1'b1;
    cycles(8);
    req_valid = 2'b00;
    cycles(6);

    // Reset while an operation is in EXEC.
    set_req(0, `MATH_MUL, 8'd77, 8'd3, 1'b1);
    req_valid = 2'b01;
    @(posedge clk);
    #3 rst_n = 1'b0;
    req_valid = 2'b00;
    #1 check_reset_values("abort");
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    set_req(0, `MATH_ADD, 8'd10, 8'd20, 1'b0);
    set_req(1, `MATH_ADD, 8'd30, 8'd40, 1'b0);
    req_valid = 2'b11;
    cycles(10);
    req_valid = 2'b00;
    cycles(6);

    // Random traffic.
    repeat (600) begin
      req_valid = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++)
        set_req(k, rnd_op(), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 1'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycles(1);
    end

    req_valid = 2'b00;
    rsp_ready = 1'b1;
    cycles(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
